// File: rtl/pdm_pwm_dac5.sv
// 5-bit DAC modulator for the 8-in/8-out user tile.
// It turns a stored level into a first-order PDM stream, a 32-clock PWM wave and a period strobe.
module pdm_pwm_dac5 (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned LEVEL_W = 5;
    localparam int unsigned CNT_W   = 5;

    logic               clk;
    logic               rst_n;
    logic               write_en;
    logic [LEVEL_W-1:0] pdm_input;

    assign rst_n     = io_in[0];
    assign clk       = io_in[1];
    assign write_en  = io_in[2];
    assign pdm_input = io_in[7:3];

    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               pdm;
    logic               pwm;
    logic               strobe;
    logic [LEVEL_W:0]   sum;

    // The carry out of the accumulator is the PDM bit; acc wraps modulo 32.
    assign sum = {1'b0, acc} + {1'b0, level};

    // Every state update reads the level from before this edge, so a write lands one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= '0;
            acc    <= '0;
            cnt    <= '0;
            pdm    <= 1'b0;
            pwm    <= 1'b0;
            strobe <= 1'b0;
        end else begin
            if (write_en) begin
                level <= pdm_input;
            end
            acc    <= sum[LEVEL_W-1:0];
            pdm    <= sum[LEVEL_W];
            cnt    <= cnt + CNT_W'(1);
            pwm    <= (cnt < level);
            strobe <= (cnt == CNT_W'(31));
        end
    end

    assign io_out = {level, strobe, pwm, pdm};

endmodule

// File: tb/tb_pdm_pwm_dac5.sv
// Directed self-checking bench for pdm_pwm_dac5.
// Expected densities, duties, spacings and reset values are worked out by hand.
module tb_pdm_pwm_dac5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       write_en = 1'b0;
    logic [4:0] din = 5'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int tests = 0;
    int fails = 0;

    int ones, pwm_a, pwm_b, strb, bad;

    assign io_in = {din, write_en, clk, rst_n};

    pdm_pwm_dac5 dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts outputs over n edges; bad collects PDM gap, strobe period and readback deviations.
    task automatic measure(input int n, input int gap, input int rb,
                           output int n_ones, output int n_pwm_a, output int n_pwm_b,
                           output int n_strb, output int n_bad);
        int last_p = -1;
        int last_s = -1;
        n_ones = 0; n_pwm_a = 0; n_pwm_b = 0; n_strb = 0; n_bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (io_out[0]) begin
                if (gap > 0 && last_p >= 0 && (i - last_p) != gap) n_bad++;
                last_p = i;
                n_ones++;
            end
            if (io_out[1]) begin
                if (i < 32) n_pwm_a++;
                else n_pwm_b++;
            end
            if (io_out[2]) begin
                if (last_s >= 0 && (i - last_s) != 32) n_bad++;
                last_s = i;
                n_strb++;
            end
            if (int'(io_out[7:3]) != rb) n_bad++;
        end
    endtask

    initial begin
        // Reset held across several edges
        #3 rst_n = 1'b0;
        #1 check("reset_async_initial", int'(io_out), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (io_out !== 8'h00) bad++;
        end
        check("reset_held_edges", bad, 0);

        // Release: level 0 keeps pdm and pwm low, readback zero
        @(negedge clk);
        rst_n = 1'b1;
        measure(64, 0, 0, ones, pwm_a, pwm_b, strb, bad);
        check("lvl0_pdm_ones", ones, 0);
        check("lvl0_pwm", pwm_a + pwm_b, 0);
        check("lvl0_strobe_count", strb, 2);
        check("lvl0_bad", bad, 0);

        // Single-cycle write of 8
        din = 5'h08; write_en = 1'b1;
        step();
        write_en = 1'b0; din = 5'h00;
        check("wr8_readback", int'(io_out[7:3]), 8);
        measure(64, 4, 8, ones, pwm_a, pwm_b, strb, bad);
        check("wr8_pdm_ones", ones, 16);
        check("wr8_pwm_a", pwm_a, 8);
        check("wr8_pwm_b", pwm_b, 8);
        check("wr8_strobe_count", strb, 2);
        check("wr8_bad", bad, 0);

        // Single-cycle write of 0x1a
        din = 5'h1a; write_en = 1'b1;
        step();
        write_en = 1'b0; din = 5'h00;
        check("wr1a_readback", int'(io_out[7:3]), 26);
        measure(64, 0, 26, ones, pwm_a, pwm_b, strb, bad);
        check("wr1a_pdm_ones", ones, 52);
        check("wr1a_pwm_a", pwm_a, 26);
        check("wr1a_pwm_b", pwm_b, 26);
        check("wr1a_bad", bad, 0);

        // write_en held high with 0x0f
        din = 5'h0f; write_en = 1'b1;
        step();
        check("hold0f_readback", int'(io_out[7:3]), 15);
        measure(64, 0, 15, ones, pwm_a, pwm_b, strb, bad);
        check("hold0f_pdm_ones", ones, 30);
        check("hold0f_pwm", pwm_a + pwm_b, 30);
        check("hold0f_bad", bad, 0);

        // Still held, input changes to 4
        din = 5'h04;
        step();
        check("hold04_readback", int'(io_out[7:3]), 4);
        measure(64, 8, 4, ones, pwm_a, pwm_b, strb, bad);
        check("hold04_pdm_ones", ones, 8);
        check("hold04_pwm_a", pwm_a, 4);
        check("hold04_pwm_b", pwm_b, 4);
        check("hold04_strobe_count", strb, 2);
        check("hold04_bad", bad, 0);

        // Top level: 31/32 duty, never 100%
        din = 5'h1f;
        step();
        write_en = 1'b0;
        measure(64, 0, 31, ones, pwm_a, pwm_b, strb, bad);
        check("lvl31_pdm_ones", ones, 62);
        check("lvl31_pwm_a", pwm_a, 31);
        check("lvl31_pwm_b", pwm_b, 31);
        check("lvl31_bad", bad, 0);

        // Reset asserted between edges mid-pattern
        step();
        #2 rst_n = 1'b0;
        #1 check("reset_async_mid", int'(io_out), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (io_out !== 8'h00) bad++;
        end
        check("reset_mid_held", bad, 0);

        // After release the level stays cleared
        @(negedge clk);
        rst_n = 1'b1;
        measure(40, 0, 0, ones, pwm_a, pwm_b, strb, bad);
        check("post_reset_pdm", ones, 0);
        check("post_reset_pwm", pwm_a + pwm_b, 0);
        check("post_reset_bad", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
